// File: rtl/guess_solver_if.sv
// Game-side interface of the automatic guesser: feedback in, guess digits and display out.
// The master modport is the solver; the slave modport is the game (or a bench acting as it).
interface guess_solver_if;
    logic       start;
    logic [9:0] feedback;
    logic       fb_valid;
    logic [3:0] guess1;
    logic [3:0] guess10;
    logic [3:0] guess100;
    logic [7:0] seven1;
    logic [7:0] seven10;
    logic [7:0] seven100;
    logic       guess_valid;
    logic       done;
    logic       error;
    logic [3:0] guess_count;

    modport master (
        input  start, feedback, fb_valid,
        output guess1, guess10, guess100, seven1, seven10, seven100,
               guess_valid, done, error, guess_count
    );

    modport slave (
        output start, feedback, fb_valid,
        input  guess1, guess10, guess100, seven1, seven10, seven100,
               guess_valid, done, error, guess_count
    );
endinterface

// File: rtl/guess_solver.sv
// Binary-search player for the three-digit guess game. Each guess is converted to BCD
// with a sequential shift-add-3 (one bit per clock) before it is presented.
module guess_solver #(
    parameter int unsigned MAX_VAL = 999
) (
    input  logic           clk,
    input  logic           rst_n,
    guess_solver_if.master gif
);
    localparam logic [9:0] MAX     = 10'(MAX_VAL);
    localparam logic [9:0] FB_HIGH = 10'b1111100000;
    localparam logic [9:0] FB_LOW  = 10'b0000011111;
    localparam logic [9:0] FB_OK   = 10'b1111111111;
    localparam logic [7:0] SEG_DASH  = 8'b10111111;
    localparam logic [7:0] SEG_BLANK = 8'b11111111;

    typedef enum logic [2:0] {IDLE, CALC, CONV, WAIT, DONE, ERR} state_t;

    state_t          state_reg, state_next;
    logic [9:0]      lo_reg, lo_next;
    logic [9:0]      hi_reg, hi_next;
    logic [9:0]      mid_reg, mid_next;
    logic [9:0]      bin_reg, bin_next;
    logic [11:0]     bcd_reg, bcd_next;
    logic [3:0]      iter_reg, iter_next;
    logic [3:0]      count_reg, count_next;
    logic [2:0][3:0] digit_reg, digit_next;
    logic [2:0][7:0] seven_reg, seven_next;
    logic            gv_reg, gv_next;
    logic            done_reg, done_next;
    logic            error_reg, error_next;

    logic [10:0]     mid_sum;
    logic [9:0]      mid_calc;
    logic [9:0]      lo_inc;
    logic [9:0]      hi_dec;
    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_shift;
    logic [2:0][7:0] seg_code;
    logic            inconsistent;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'b11000000;
            4'd1:    seg7 = 8'b11111001;
            4'd2:    seg7 = 8'b10100100;
            4'd3:    seg7 = 8'b10110000;
            4'd4:    seg7 = 8'b10011001;
            4'd5:    seg7 = 8'b10010010;
            4'd6:    seg7 = 8'b10000010;
            4'd7:    seg7 = 8'b11111000;
            4'd8:    seg7 = 8'b10000000;
            4'd9:    seg7 = 8'b10010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // 11-bit sum so lo+hi never wraps before halving
    assign mid_sum  = {1'b0, lo_reg} + {1'b0, hi_reg};
    assign mid_calc = 10'(mid_sum >> 1);
    assign lo_inc   = mid_reg + 10'd1;
    assign hi_dec   = mid_reg - 10'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
            assign seg_code[gi] = seg7(bcd_shift[gi*4 +: 4]);
        end
    endgenerate

    assign bcd_shift = (bcd_adj << 1) | {11'd0, bin_reg[9]};

    always_comb begin
        state_next   = state_reg;
        lo_next      = lo_reg;
        hi_next      = hi_reg;
        mid_next     = mid_reg;
        bin_next     = bin_reg;
        bcd_next     = bcd_reg;
        iter_next    = iter_reg;
        count_next   = count_reg;
        digit_next   = digit_reg;
        seven_next   = seven_reg;
        gv_next      = gv_reg;
        done_next    = done_reg;
        error_next   = error_reg;
        inconsistent = 1'b0;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (gif.start) begin
                    state_next = CALC;
                    lo_next    = '0;
                    hi_next    = MAX;
                    count_next = '0;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                end
            end
            CALC: begin
                mid_next   = mid_calc;
                bin_next   = mid_calc;
                bcd_next   = '0;
                iter_next  = '0;
                state_next = CONV;
            end
            CONV: begin
                bcd_next  = bcd_shift;
                bin_next  = {bin_reg[8:0], 1'b0};
                iter_next = iter_reg + 4'd1;
                if (iter_reg == 4'd9) begin
                    digit_next = bcd_shift;
                    seven_next = seg_code;
                    count_next = (count_reg == 4'd15) ? count_reg : count_reg + 4'd1;
                    gv_next    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (gif.fb_valid) begin
                    case (gif.feedback)
                        FB_LOW: begin
                            if (mid_reg == MAX || lo_inc > hi_reg) begin
                                inconsistent = 1'b1;
                            end else begin
                                lo_next    = lo_inc;
                                gv_next    = 1'b0;
                                state_next = CALC;
                            end
                        end
                        FB_HIGH: begin
                            if (mid_reg == 10'd0 || lo_reg > hi_dec) begin
                                inconsistent = 1'b1;
                            end else begin
                                hi_next    = hi_dec;
                                gv_next    = 1'b0;
                                state_next = CALC;
                            end
                        end
                        FB_OK: begin
                            done_next  = 1'b1;
                            gv_next    = 1'b0;
                            state_next = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase

        if (inconsistent) begin
            state_next = ERR;
            error_next = 1'b1;
            gv_next    = 1'b0;
            seven_next = {3{SEG_DASH}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            mid_reg   <= '0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            count_reg <= '0;
            digit_reg <= '0;
            seven_reg <= {3{SEG_BLANK}};
            gv_reg    <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            mid_reg   <= mid_next;
            bin_reg   <= bin_next;
            bcd_reg   <= bcd_next;
            iter_reg  <= iter_next;
            count_reg <= count_next;
            digit_reg <= digit_next;
            seven_reg <= seven_next;
            gv_reg    <= gv_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    assign gif.guess1      = digit_reg[0];
    assign gif.guess10     = digit_reg[1];
    assign gif.guess100    = digit_reg[2];
    assign gif.seven1      = seven_reg[0];
    assign gif.seven10     = seven_reg[1];
    assign gif.seven100    = seven_reg[2];
    assign gif.guess_valid = gv_reg;
    assign gif.done        = done_reg;
    assign gif.error       = error_reg;
    assign gif.guess_count = count_reg;
endmodule

// File: tb/tb_guess_solver.sv
// Bench for guess_solver: plays the game side, predicts every output from the search rules
// and compares each cycle, plus literal expectations taken from hand-worked searches.
module tb_guess_solver;
    localparam int MAX = 999;
    localparam logic [9:0] FB_HIGH = 10'b1111100000;
    localparam logic [9:0] FB_LOW  = 10'b0000011111;
    localparam logic [9:0] FB_OK   = 10'b1111111111;
    localparam logic [9:0] FB_BAD  = 10'b0000000001;

    localparam int M_IDLE = 0, M_BUSY = 1, M_WAIT = 2, M_DONE = 3, M_ERR = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    guess_solver_if gif();

    guess_solver #(.MAX_VAL(MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .gif  (gif)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int seq123 [10] = '{499, 249, 124, 61, 92, 108, 116, 120, 122, 123};
    int seq0   [9]  = '{499, 249, 124, 61, 30, 14, 6, 2, 0};

    // Model state: phase, search bounds, pending guess, shown number and display mode
    int m_mode  = M_IDLE;
    int m_lo    = 0;
    int m_hi    = 0;
    int m_guess = 0;
    int m_timer = 0;
    int m_cnt   = 0;
    int m_dig   = 0;
    int m_seg   = 0;   // 0 blank, 1 digits, 2 dashes

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_val();
        return int'(gif.guess100) * 100 + int'(gif.guess10) * 10 + int'(gif.guess1);
    endfunction

    task automatic m_next_guess();
        m_guess = (m_lo + m_hi) / 2;
        m_timer = 11;
        m_mode  = M_BUSY;
    endtask

    task automatic m_fail();
        m_mode = M_ERR;
        m_seg  = 2;
    endtask

    // Behavioural game-side model of the solver
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; m_cnt = 0; m_dig = 0; m_seg = 0;
            end else begin
                case (m_mode)
                    M_IDLE, M_DONE, M_ERR: begin
                        if (gif.start) begin
                            m_lo = 0; m_hi = MAX; m_cnt = 0;
                            m_next_guess();
                        end
                    end
                    M_BUSY: begin
                        m_timer--;
                        if (m_timer == 0) begin
                            m_mode = M_WAIT;
                            m_dig  = m_guess;
                            m_seg  = 1;
                            if (m_cnt < 15) m_cnt++;
                        end
                    end
                    M_WAIT: begin
                        if (gif.fb_valid) begin
                            if (gif.feedback == FB_LOW) begin
                                if (m_guess == MAX || m_guess + 1 > m_hi) m_fail();
                                else begin m_lo = m_guess + 1; m_next_guess(); end
                            end else if (gif.feedback == FB_HIGH) begin
                                if (m_guess == 0 || m_guess - 1 < m_lo) m_fail();
                                else begin m_hi = m_guess - 1; m_next_guess(); end
                            end else if (gif.feedback == FB_OK) begin
                                m_mode = M_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        int e100, e10, e1;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("guess_valid", int'(gif.guess_valid), int'(m_mode == M_WAIT));
                chk("done", int'(gif.done), int'(m_mode == M_DONE));
                chk("error", int'(gif.error), int'(m_mode == M_ERR));
                chk("guess_count", int'(gif.guess_count), m_cnt);
                chk("digits", dut_val(), m_dig);
                if (m_mode != M_BUSY) begin
                    if (m_seg == 0) begin
                        e100 = 255; e10 = 255; e1 = 255;
                    end else if (m_seg == 2) begin
                        e100 = 191; e10 = 191; e1 = 191;
                    end else begin
                        e100 = int'(seg_tab[m_dig / 100]);
                        e10  = int'(seg_tab[(m_dig / 10) % 10]);
                        e1   = int'(seg_tab[m_dig % 10]);
                    end
                    chk("seven100", int'(gif.seven100), e100);
                    chk("seven10", int'(gif.seven10), e10);
                    chk("seven1", int'(gif.seven1), e1);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        gif.start = 1'b1;
        @(negedge clk);
        gif.start = 1'b0;
    endtask

    task automatic send_fb(input logic [9:0] p);
        @(negedge clk);
        gif.feedback = p;
        gif.fb_valid = 1'b1;
        @(negedge clk);
        gif.fb_valid = 1'b0;
        gif.feedback = '0;
    endtask

    task automatic wait_gv(output int cyc);
        cyc = 0;
        while (!gif.guess_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!gif.guess_valid) begin
            checks++;
            errors++;
            $display("FAIL guess_valid_timeout: got 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic play_step(input int secret, input int exp_guess, input bit lie_high);
        int c, v;
        wait_gv(c);
        v = dut_val();
        $display("guess %0d (count %0d) secret %0d", v, gif.guess_count, secret);
        chk("guess_seq", v, exp_guess);
        if (lie_high)          send_fb(FB_HIGH);
        else if (v > secret)   send_fb(FB_HIGH);
        else if (v < secret)   send_fb(FB_LOW);
        else                   send_fb(FB_OK);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        gif.start = 1'b0;
        gif.feedback = '0;
        gif.fb_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_guess_valid", int'(gif.guess_valid), 0);
        chk("rst_count", int'(gif.guess_count), 0);
        chk("rst_seven1", int'(gif.seven1), 255);
        chk("rst_digits", dut_val(), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Secret 123 with latency, illegal-pattern and ignored-pulse probes
        pulse_start();
        wait_gv(c);
        chk("start_latency", c, 11);
        send_fb(FB_BAD);
        repeat (3) @(negedge clk);
        chk("illegal_keeps_wait", int'(gif.guess_valid), 1);
        chk("illegal_count", int'(gif.guess_count), 1);
        for (int i = 0; i < 10; i++) begin
            play_step(123, seq123[i], 1'b0);
            if (i == 0) begin
                wait_gv(c);
                chk("fb_latency", c, 11);
            end
            if (i == 1) begin
                repeat (2) @(negedge clk);
                gif.start = 1'b1;
                gif.fb_valid = 1'b1;
                gif.feedback = FB_OK;
                @(negedge clk);
                gif.start = 1'b0;
                gif.fb_valid = 1'b0;
                gif.feedback = '0;
            end
        end
        chk("done_123", int'(gif.done), 1);
        chk("count_123", int'(gif.guess_count), 10);
        chk("seven100_123", int'(gif.seven100), 8'b11111001);
        chk("seven10_123", int'(gif.seven10), 8'b10100100);
        chk("seven1_123", int'(gif.seven1), 8'b10110000);

        // Restart from DONE, secret 0
        pulse_start();
        chk("restart_count", int'(gif.guess_count), 0);
        chk("restart_done", int'(gif.done), 0);
        for (int i = 0; i < 9; i++) play_step(0, seq0[i], 1'b0);
        chk("done_0", int'(gif.done), 1);
        chk("count_0", int'(gif.guess_count), 9);

        // Secret 0 again, lying "too high" at guess 0
        pulse_start();
        for (int i = 0; i < 9; i++) play_step(0, seq0[i], i == 8);
        chk("err_flag", int'(gif.error), 1);
        chk("err_seven100", int'(gif.seven100), 8'b10111111);
        chk("err_seven10", int'(gif.seven10), 8'b10111111);
        chk("err_seven1", int'(gif.seven1), 8'b10111111);

        // Restart from ERR, then reset between edges during CONV of guess 3
        pulse_start();
        chk("err_restart_count", int'(gif.guess_count), 0);
        chk("err_restart_error", int'(gif.error), 0);
        play_step(123, 499, 1'b0);
        play_step(123, 249, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(gif.guess_count), 0);
        chk("async_rst_digits", dut_val(), 0);
        chk("async_rst_seven10", int'(gif.seven10), 255);
        chk("async_rst_gv", int'(gif.guess_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_gv(c);
        chk("after_rst_first_guess", dut_val(), 499);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/guess_solver.md
# guess_solver

Automatic player for the three-digit guess-number game: it runs a binary search over 0..MAX_VAL, presents each guess as BCD digits and active-low seven-segment patterns, and consumes the game's 10-LED higher/lower/correct feedback until the secret is found. It sits on the guessing side of the game interface, in place of the human push-button player. Binary-to-BCD conversion is sequential (shift-add-3, one bit per clock).

## Interface
- MAX_VAL, 999, upper bound of the search range, inclusive; legal range 1..999, 10-bit arithmetic.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled each edge; begins a new search from IDLE, DONE or ERR.
- feedback  in  10  LED pattern from the game. 10'b1111100000 = guess too high; 10'b0000011111 = guess too low; 10'b1111111111 = correct.
- fb_valid  in  1  feedback qualifier, one cycle; sampled only in WAIT.
- guess1, guess10, guess100  out  4 each  BCD digits of the current guess.
- seven1, seven10, seven100  out  8 each  active-low segment patterns, bit7 = dp (always 1).
- guess_valid  out  1  guess digits stable and awaiting feedback.
- done  out  1  last guess was confirmed correct.
- error  out  1  feedback was inconsistent.
- guess_count  out  4  guesses issued in the current search.

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- States: IDLE, CALC, CONV, WAIT, DONE, ERR.
- IDLE: start=1 -> CALC; load lo=0, hi=MAX_VAL, guess_count=0; clear done and error.
- CALC, one cycle: mid=(lo+hi)>>1, computed with an 11-bit sum; load the shift register; iter=0; go to CONV.
- CONV, 10 cycles: one shift-add-3 iteration per cycle, MSB of mid first. After the 10th iteration: latch the BCD digits, increment guess_count, go to WAIT.
- WAIT: guess_valid=1. On fb_valid=1, decode feedback:
  - too low: if mid==MAX_VAL go to ERR; else lo=mid+1.
  - too high: if mid==0 go to ERR; else hi=mid-1.
  - After either update: if lo>hi go to ERR; else go to CALC.
  - correct: go to DONE.
  - any other pattern: ignored; stay in WAIT; no counter change.
- DONE: done=1; the digits hold the answer. start=1 -> new search.
- ERR: error=1; all three seven-segment outputs show 8'b10111111 (dash). start=1 -> new search.
- start is ignored in CALC, CONV and WAIT. fb_valid is ignored outside WAIT.
- Seven-segment encoding, digit -> pattern:
  - 0 -> 8'b11000000; 1 -> 11111001; 2 -> 10100100; 3 -> 10110000; 4 -> 10011001
  - 5 -> 10010010; 6 -> 10000010; 7 -> 11111000; 8 -> 10000000; 9 -> 10010000
- Display content per state:
  - IDLE: segment outputs are 8'b11111111 (blank).
  - CALC and CONV: segment outputs hold the previous guess's patterns.
  - WAIT and DONE: segment outputs show the latched digits.
- guess_count saturates at 15. With MAX_VAL=999 a consistent search needs at most 10 guesses.

## Timing
- Reset values: guess digits 0, seven* 8'b11111111, guess_valid 0, done 0, error 0, guess_count 0, state IDLE.
- rst_n low during any state: immediate return to reset values, with no wait for a clock edge.
- Latency, start to first guess: start sampled at edge N -> CALC; CONV from edge N+1; guess_valid=1 after edge N+11.
- Latency, feedback to next guess: fb_valid sampled at edge M -> guess_valid falls after edge M; next guess_valid=1 after edge M+11.
- Latency, correct feedback: fb_valid at edge M -> done=1 after edge M. guess_valid drops at the same time.
- Latency, inconsistent feedback: error=1 after edge M.
- Outputs are registered; digits change only at the end of CONV.

## Test plan
- Secret 123, bench answers honestly: guesses are 499, 249, 124, 61, 92, 108, 116, 120, 122, 123 -> done=1, guess_count=10, seven100/10/1 = 11111001 / 10100100 / 10110000.
- Secret 0: guesses are 499, 249, 124, 61, 30, 14, 6, 2, 0 -> done=1, guess_count=9. Repeat, but answer "too high" at guess 0 -> error=1, all segments 8'b10111111.
- Latency: start at edge 0 -> guess_valid first high after edge 11. fb_valid with an illegal pattern 10'b0000000001 -> state stays WAIT, guess_count unchanged.
- Reset mid-search: assert rst_n=0 during CONV of guess 3, between edges -> outputs return to reset values immediately. A subsequent start restarts the search at guess 499.
- Restart from DONE and from ERR via start=1 -> guess_count=0, then first guess 499. fb_valid pulses and start pulses issued during CONV -> ignored.
